// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_hazard_ctrl_pkg : shared state encodings and width defaults
// Revision 1.0
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_RA_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_REDIR = 2'd1,
    ST_DRAIN = 2'd2
  } hz_state_e;

  // Hazard priority, highest first:
  //   1. dmem busy   : stall F/D/E/M, bubble W
  //   2. mc busy     : stall F/D/E, bubble M
  //   3. mispredict, fetch ready : redirect, bubble D/E
  //   4. mispredict, fetch busy  : park target, stall F, bubble D/E
  //   5. load-use    : stall F/D, bubble E
  //   6. fence with older instrs in flight : stall F/D, bubble E, drain

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ============================================================================
// hazard_detect : load-use compare between execute rd and decode sources
// Revision 1.0
// ============================================================================
`default_nettype none

module hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] decode_i_rs1,
  input  logic [RA_W-1:0] decode_i_rs2,
  input  logic            decode_i_use_rs1,
  input  logic            decode_i_use_rs2,
  input  logic [RA_W-1:0] execute_i_rd,
  input  logic            execute_i_is_load,
  output logic            load_use_o
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never blocks a reader.
  assign rd_live    = execute_i_is_load && (execute_i_rd != '0);
  assign rs1_hit    = decode_i_use_rs1 && (decode_i_rs1 == execute_i_rd);
  assign rs2_hit    = decode_i_use_rs2 && (decode_i_rs2 == execute_i_rd);
  assign load_use_o = rd_live && (rs1_hit || rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/bubble sequencer and fetch redirect for rv32I pipe
// Optional counters enabled by PIPE_HAZARD_CTRL_PERF_EN. Revision 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int RA_W  = DEF_RA_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  decode_i_rs1,
  input  logic [RA_W-1:0]  decode_i_rs2,
  input  logic             decode_i_use_rs1,
  input  logic             decode_i_use_rs2,
  input  logic             decode_i_fence,
  input  logic [RA_W-1:0]  execute_i_rd,
  input  logic             execute_i_is_load,
  input  logic             execute_i_mispredict,
  input  logic [XLEN-1:0]  execute_i_target_pc,
  input  logic             execute_i_mc_busy,
  input  logic             regE_i_commit,
  input  logic             regM_i_commit,
  input  logic             regW_i_commit,
  input  logic             imem_i_busy,
  input  logic             dmem_i_busy,
  output logic             ctrl_o_regF_stall,
  output logic             ctrl_o_regD_stall,
  output logic             ctrl_o_regD_bubble,
  output logic             ctrl_o_regE_stall,
  output logic             ctrl_o_regE_bubble,
  output logic             ctrl_o_regM_stall,
  output logic             ctrl_o_regM_bubble,
  output logic             ctrl_o_regW_bubble,
  output logic             ctrl_o_redirect_valid,
  output logic [XLEN-1:0]  ctrl_o_redirect_pc,
  output logic [CNT_W-1:0] ctrl_o_perf_stall,
  output logic [CNT_W-1:0] ctrl_o_perf_flush
);

  hz_state_e       state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            load_use;
  logic            any_commit;

  hazard_detect #(.RA_W(RA_W)) u_hazard_detect (
    .decode_i_rs1      (decode_i_rs1),
    .decode_i_rs2      (decode_i_rs2),
    .decode_i_use_rs1  (decode_i_use_rs1),
    .decode_i_use_rs2  (decode_i_use_rs2),
    .execute_i_rd      (execute_i_rd),
    .execute_i_is_load (execute_i_is_load),
    .load_use_o        (load_use)
  );

  assign any_commit = regE_i_commit || regM_i_commit || regW_i_commit;

  always_comb begin
    ctrl_o_regF_stall     = 1'b0;
    ctrl_o_regD_stall     = 1'b0;
    ctrl_o_regD_bubble    = 1'b0;
    ctrl_o_regE_stall     = 1'b0;
    ctrl_o_regE_bubble    = 1'b0;
    ctrl_o_regM_stall     = 1'b0;
    ctrl_o_regM_bubble    = 1'b0;
    ctrl_o_regW_bubble    = 1'b0;
    ctrl_o_redirect_valid = 1'b0;
    ctrl_o_redirect_pc    = '0;
    state_d               = state_q;
    pend_pc_d             = pend_pc_q;

    if (rst) begin
      ctrl_o_regD_bubble = 1'b1;
      ctrl_o_regE_bubble = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
      state_d            = ST_RUN;
      pend_pc_d          = '0;
    end else if (dmem_i_busy) begin
      // Back-pressure freezes everything up to M; state and parked pc survive.
      ctrl_o_regF_stall  = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_stall  = 1'b1;
      ctrl_o_regW_bubble = 1'b1;
    end else if (execute_i_mc_busy) begin
      ctrl_o_regF_stall  = 1'b1;
      ctrl_o_regD_stall  = 1'b1;
      ctrl_o_regE_stall  = 1'b1;
      ctrl_o_regM_bubble = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (execute_i_mispredict) begin
            ctrl_o_regD_bubble = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            if (!imem_i_busy) begin
              ctrl_o_redirect_valid = 1'b1;
              ctrl_o_redirect_pc    = execute_i_target_pc;
            end else begin
              ctrl_o_regF_stall = 1'b1;
              pend_pc_d         = execute_i_target_pc;
              state_d           = ST_REDIR;
            end
          end else if (load_use) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
          end else if (decode_i_fence && any_commit) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
            state_d            = ST_DRAIN;
          end
        end
        ST_REDIR: begin
          // Whatever fetch returns meanwhile is wrong-path and is dropped in D.
          ctrl_o_regD_bubble = 1'b1;
          if (imem_i_busy) begin
            ctrl_o_regF_stall = 1'b1;
          end else begin
            ctrl_o_redirect_valid = 1'b1;
            ctrl_o_redirect_pc    = pend_pc_q;
            state_d               = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (any_commit) begin
            ctrl_o_regF_stall  = 1'b1;
            ctrl_o_regD_stall  = 1'b1;
            ctrl_o_regE_bubble = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
  logic             flush_accept;

  // Mispredict acceptance mirrors rules 3/4: only in RUN and not overridden.
  assign flush_accept = !rst && !dmem_i_busy && !execute_i_mc_busy &&
                        (state_q == ST_RUN) && execute_i_mispredict;

  always_comb begin
    perf_stall_d = perf_stall_q + {{(CNT_W-1){1'b0}}, ctrl_o_regF_stall};
    perf_flush_d = perf_flush_q + {{(CNT_W-1){1'b0}}, flush_accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign ctrl_o_perf_stall = perf_stall_q;
  assign ctrl_o_perf_flush = perf_flush_q;
`else
  assign ctrl_o_perf_stall = '0;
  assign ctrl_o_perf_flush = '0;
`endif

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/bubble sequencer for the 5-stage rv32I pipeline.
- Drives stall/bubble controls of the F/D/E/M/W pipeline registers, plus the fetch redirect.
- Resolves load-use hazards, branch mispredict flushes, fence drains and memory/multicycle back-pressure in one cycle.
- Holds a mispredict redirect that arrives while instruction memory is busy.

Parameters:
- XLEN, 32, pc/data width
- RA_W, 5, register address width
- CNT_W, 32, perf counter width (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- decode_i_rs1  in  RA_W  decode rs1 address
- decode_i_rs2  in  RA_W  decode rs2 address
- decode_i_use_rs1  in  1  decode reads rs1
- decode_i_use_rs2  in  1  decode reads rs2
- decode_i_fence  in  1  fence in decode
- execute_i_rd  in  RA_W  execute destination
- execute_i_is_load  in  1  execute holds a load
- execute_i_mispredict  in  1  branch/jump resolved wrong
- execute_i_target_pc  in  XLEN  correct pc
- execute_i_mc_busy  in  1  multicycle unit busy
- regE_i_commit, regM_i_commit, regW_i_commit  in  1 each  stage holds a valid instr
- imem_i_busy  in  1  fetch cannot accept a new pc
- dmem_i_busy  in  1  data access pending in M
- ctrl_o_regF_stall, ctrl_o_regD_stall, ctrl_o_regD_bubble, ctrl_o_regE_stall, ctrl_o_regE_bubble, ctrl_o_regM_stall, ctrl_o_regM_bubble, ctrl_o_regW_bubble  out  1 each
- ctrl_o_redirect_valid  out  1  fetch takes ctrl_o_redirect_pc
- ctrl_o_redirect_pc  out  XLEN  redirect target
- ctrl_o_perf_stall, ctrl_o_perf_flush  out  CNT_W each  counters

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. State=RUN, pend_pc=0, counters=0.
- Outputs while rst=1: all stalls 0, all bubbles 1, redirect_valid 0, redirect_pc 0.
- Outputs are combinational from inputs and state (zero latency). State updates on posedge clk.
- Priority, highest first; each lower rule applies only if no higher rule fires:
  1. dmem_busy: stall F, D, E, M; bubble W.
  2. mc_busy: stall F, D, E; bubble M.
  3. mispredict, RUN, !imem_busy: redirect_valid=1, redirect_pc=target; bubble D and E. Stay in RUN.
  4. mispredict, RUN, imem_busy: latch pend_pc=target; bubble D, E; stall F; go to REDIR. No redirect this cycle.
  5. load-use: execute_i_is_load && execute_i_rd!=0 && rd matches a used rs. Stall F, D; bubble E.
  6. fence in RUN: any of regE/M/W_commit set -> stall F, D; bubble E; go to DRAIN. All clear -> pass.
- REDIR state:
  - While imem_busy: stall F; bubble D (wrong-path returns discarded).
  - First cycle !imem_busy: redirect_valid=1, redirect_pc=pend_pc; bubble D; go to RUN.
  - Rules 1 and 2 override REDIR outputs, but the state and pend_pc are kept.
- DRAIN state:
  - While any commit is set: stall F, D; bubble E.
  - When all clear: no stall on this cycle (fence advances); go to RUN.
  - A mispredict cannot occur in DRAIN because E holds bubbles. If one is asserted, it is ignored.
- Simultaneous events:
  - mispredict with load-use: mispredict wins; the load-use instr is flushed.
  - dmem_busy with mispredict: mispredict is held by the stalled E and handled once dmem frees.
- rst mid-REDIR or mid-DRAIN: immediate return to RUN; pending redirect dropped.
- Register x0 never creates a hazard.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - perf_stall increments on any cycle with regF_stall=1.
  - perf_flush increments on every mispredict acceptance (rules 3/4).
  - Both wrap modulo 2^CNT_W and clear on rst.
- Undefined: no counter flops; both outputs tied to 0.

Decomposition:
- Shared package/define file holds:
  - state encodings ST_RUN=2'd0, ST_REDIR=2'd1, ST_DRAIN=2'd2
  - hazard priority comments
  - RA_W/XLEN defaults
- Sub-module hazard_detect: combinational load-use compare, output one bit.
- FSM and output muxing stay in the top module.

Test Plan:
- Load x5 in E, decode rs1=5, use_rs1=1 -> F/D stall=1, E bubble=1 for one cycle. Then a decode with rs1=0 and rd=0 -> no stall.
- Mispredict, target 0x80000040, imem idle -> redirect_valid=1, pc=0x80000040, D/E bubble=1 in the same cycle.
- Mispredict, target 0x80000100, imem_busy for 3 cycles -> 3 cycles F stall with D bubble. Then redirect_valid=1, pc=0x80000100 on cycle 4; state back to RUN.
- Fence with E/M/W commits set, clearing one per cycle -> 3 cycles F/D stall with E bubble; no stall on cycle 4.
- dmem_busy with mispredict and load-use together -> only F/D/E/M stall and W bubble. After dmem frees, redirect fires.
- rst asserted in REDIR -> all bubbles=1, redirect_valid=0 during rst. After release, state RUN; pending pc not emitted. With the macro defined, both counters read 0.
